// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - ALU control decode with valid/ready issue stage and 2-entry skid buffer
//
// Decodes alu_op/funct3/funct7_5 into a 4-bit alu_control code and issues it
// with both operands through a valid/ready stage.  Outputs always come from
// the MAIN register; SKID holds a second beat when the ALU side stalls.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               kill all held entries (MAIN payload left as is)
//   in_valid/in_ready   upstream handshake
//   alu_op, funct3,     decode inputs
//   funct7_5
//   data1_in, data2_in  operands (DATA_W bits)
//   out_valid/out_ready downstream handshake
//   alu_control, data1, issued beat
//   data2, illegal

module alu_ctrl_issue #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic [DATA_W-1:0] data1_in,
  input  logic [DATA_W-1:0] data2_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              illegal
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        main_ctrl_q, main_ctrl_d;
  logic              main_ill_q,  main_ill_d;
  logic [DATA_W-1:0] main_d1_q,   main_d1_d;
  logic [DATA_W-1:0] main_d2_q,   main_d2_d;

  logic [3:0]        skid_ctrl_q, skid_ctrl_d;
  logic              skid_ill_q,  skid_ill_d;
  logic [DATA_W-1:0] skid_d1_q,   skid_d1_d;
  logic [DATA_W-1:0] skid_d2_q,   skid_d2_d;

  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic       accept;
  logic       pop;

  assign in_ready    = (state_q != FULL);
  assign out_valid   = (state_q != EMPTY);
  assign alu_control = main_ctrl_q;
  assign illegal     = main_ill_q;
  assign data1       = main_d1_q;
  assign data2       = main_d2_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Decode of the incoming beat; unsupported encodings fall back to ADD.
  always_comb begin
    dec_ctrl = CTRL_ADD;
    dec_ill  = 1'b0;
    case (alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  dec_ctrl = funct7_5 ? CTRL_SUB : CTRL_ADD;
          3'b111:  dec_ctrl = CTRL_AND;
          3'b110:  dec_ctrl = CTRL_OR;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_ill_d  = main_ill_q;
    main_d1_d   = main_d1_q;
    main_d2_d   = main_d2_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_ill_d  = skid_ill_q;
    skid_d1_d   = skid_d1_q;
    skid_d2_d   = skid_d2_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_ctrl_d = dec_ctrl;
          main_ill_d  = dec_ill;
          main_d1_d   = data1_in;
          main_d2_d   = data2_in;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_ctrl_d = dec_ctrl;
          main_ill_d  = dec_ill;
          main_d1_d   = data1_in;
          main_d2_d   = data2_in;
        end else if (accept) begin
          state_d     = FULL;
          skid_ctrl_d = dec_ctrl;
          skid_ill_d  = dec_ill;
          skid_d1_d   = data1_in;
          skid_d2_d   = data2_in;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move the stage.
        if (pop) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_ill_d  = skid_ill_q;
          main_d1_d   = skid_d1_q;
          main_d2_d   = skid_d2_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over accept/pop: drop everything, keep payload registers.
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = main_ctrl_q;
      main_ill_d  = main_ill_q;
      main_d1_d   = main_d1_q;
      main_d2_d   = main_d2_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_ill_d  = skid_ill_q;
      skid_d1_d   = skid_d1_q;
      skid_d2_d   = skid_d2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_ctrl_q <= 4'b0000;
      main_ill_q  <= 1'b0;
      main_d1_q   <= '0;
      main_d2_q   <= '0;
      skid_ctrl_q <= 4'b0000;
      skid_ill_q  <= 1'b0;
      skid_d1_q   <= '0;
      skid_d2_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_ill_q  <= main_ill_d;
      main_d1_q   <= main_d1_d;
      main_d2_q   <= main_d2_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_ill_q  <= skid_ill_d;
      skid_d1_q   <= skid_d1_d;
      skid_d2_q   <= skid_d2_d;
    end
  end

endmodule
